// File: rtl/quad_xfer.sv
// rtl/quad_xfer.sv - whole-quad transfer sequencer in front of quad_mem
//
// Purpose: accepts one quad request (read or write of fields T/X/Y/Z at one
// quad address in one bank), issues the four field accesses to quad_mem on
// consecutive cycles, absorbs the one-cycle registered read latency, and
// returns the assembled quad or a write acknowledge on a response channel.
//
// Ports:
//   i_clk, i_rst_n                       clock, synchronous active-low reset
//   i_req_valid / o_req_ready            request handshake
//   i_req_wr, i_req_bank, i_req_addr     request kind, bank, quad address
//   i_req_t/x/y/z                        write data (ignored on read)
//   o_rsp_valid / i_rsp_ready            response handshake
//   o_rsp_err, o_rsp_t/x/y/z             bank-3 error flag, read data
//   o_mem_cs_ram/rom0/rom1, o_mem_wr     quad_mem selects and write strobe
//   o_mem_addr, o_mem_field, o_mem_data  quad_mem address, field, write data
//   i_mem_data                           quad_mem registered read data
module quad_xfer #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wr,
  input  logic [1:0]         i_req_bank,
  input  logic [ADDR_SZ-1:0] i_req_addr,
  input  logic [DATA_SZ-1:0] i_req_t,
  input  logic [DATA_SZ-1:0] i_req_x,
  input  logic [DATA_SZ-1:0] i_req_y,
  input  logic [DATA_SZ-1:0] i_req_z,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_err,
  output logic [DATA_SZ-1:0] o_rsp_t,
  output logic [DATA_SZ-1:0] o_rsp_x,
  output logic [DATA_SZ-1:0] o_rsp_y,
  output logic [DATA_SZ-1:0] o_rsp_z,
  output logic               o_mem_cs_ram,
  output logic               o_mem_cs_rom0,
  output logic               o_mem_cs_rom1,
  output logic               o_mem_wr,
  output logic [ADDR_SZ-1:0] o_mem_addr,
  output logic [1:0]         o_mem_field,
  output logic [DATA_SZ-1:0] o_mem_data,
  input  logic [DATA_SZ-1:0] i_mem_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state_q;
  logic [1:0]         fld_q;
  logic [1:0]         bank_q;
  logic [ADDR_SZ-1:0] addr_q;
  logic [DATA_SZ-1:0] wdat_q [4];

  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [DATA_SZ-1:0] rsp_q [4];

  logic               cs_ram_q;
  logic               cs_rom0_q;
  logic               cs_rom1_q;
  logic               mem_wr_q;
  logic [ADDR_SZ-1:0] mem_addr_q;
  logic [1:0]         mem_field_q;
  logic [DATA_SZ-1:0] mem_data_q;

  // Field to be issued next cycle, and the field whose read data is on
  // i_mem_data this cycle (issued one cycle earlier).
  logic [1:0] fld_d;
  logic [1:0] fld_prev;
  assign fld_d    = fld_q + 2'd1;
  assign fld_prev = fld_q - 2'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      fld_q       <= 2'd0;
      bank_q      <= 2'd0;
      addr_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cs_ram_q    <= 1'b0;
      cs_rom0_q   <= 1'b0;
      cs_rom1_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_field_q <= 2'd0;
      mem_data_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        wdat_q[i] <= '0;
        rsp_q[i]  <= '0;
      end
    end else begin
      // Memory strobes are single-cycle; each issue cycle re-asserts them.
      cs_ram_q    <= 1'b0;
      cs_rom0_q   <= 1'b0;
      cs_rom1_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_field_q <= 2'd0;
      mem_data_q  <= '0;

      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            bank_q      <= i_req_bank;
            addr_q      <= i_req_addr;
            wdat_q[0]   <= i_req_t;
            wdat_q[1]   <= i_req_x;
            wdat_q[2]   <= i_req_y;
            wdat_q[3]   <= i_req_z;
            fld_q       <= 2'd0;
            req_ready_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) rsp_q[i] <= '0;
            if (i_req_bank == 2'd3) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              // Field T goes out in the first cycle after the accept.
              cs_ram_q    <= (i_req_bank == 2'd0);
              cs_rom0_q   <= (i_req_bank == 2'd1);
              cs_rom1_q   <= (i_req_bank == 2'd2);
              mem_addr_q  <= i_req_addr;
              mem_field_q <= 2'd0;
              if (i_req_wr) begin
                mem_wr_q   <= 1'b1;
                mem_data_q <= i_req_t;
                state_q    <= WRITE;
              end else begin
                state_q    <= READ;
              end
            end
          end
        end

        READ: begin
          if (fld_q != 2'd0) rsp_q[fld_prev] <= i_mem_data;
          if (fld_q == 2'd3) begin
            state_q <= DRAIN;
            fld_q   <= 2'd0;
          end else begin
            fld_q       <= fld_d;
            cs_ram_q    <= (bank_q == 2'd0);
            cs_rom0_q   <= (bank_q == 2'd1);
            cs_rom1_q   <= (bank_q == 2'd2);
            mem_addr_q  <= addr_q;
            mem_field_q <= fld_d;
          end
        end

        DRAIN: begin
          // Z was issued in the last READ cycle; its data lands now.
          rsp_q[3]    <= i_mem_data;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end

        WRITE: begin
          if (fld_q == 2'd3) begin
            fld_q       <= 2'd0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            fld_q       <= fld_d;
            cs_ram_q    <= (bank_q == 2'd0);
            cs_rom0_q   <= (bank_q == 2'd1);
            cs_rom1_q   <= (bank_q == 2'd2);
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_field_q <= fld_d;
            mem_data_q  <= wdat_q[fld_d];
          end
        end

        RESP: begin
          if (i_rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            for (int i = 0; i < 4; i++) rsp_q[i] <= '0;
          end
        end

        default: begin
          state_q     <= IDLE;
          fld_q       <= 2'd0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready   = req_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_t       = rsp_q[0];
  assign o_rsp_x       = rsp_q[1];
  assign o_rsp_y       = rsp_q[2];
  assign o_rsp_z       = rsp_q[3];
  assign o_mem_cs_ram  = cs_ram_q;
  assign o_mem_cs_rom0 = cs_rom0_q;
  assign o_mem_cs_rom1 = cs_rom1_q;
  assign o_mem_wr      = mem_wr_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_field   = mem_field_q;
  assign o_mem_data    = mem_data_q;

endmodule

// File: tb/tb_quad_xfer.sv
// tb/tb_quad_xfer.sv - scoreboard bench for quad_xfer with a quad_mem model
module tb_quad_xfer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_bank;
  logic [11:0] req_addr;
  logic [15:0] req_t, req_x, req_y, req_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [15:0] rsp_t, rsp_x, rsp_y, rsp_z;
  logic        cs_ram, cs_rom0, cs_rom1, mem_wr;
  logic [11:0] mem_addr;
  logic [1:0]  mem_field;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  logic [79:0] sb_q [$];
  logic [15:0] shadow [int];
  logic [15:0] mem [0:49151];

  always #5 clk = ~clk;

  quad_xfer #(.DATA_SZ(16), .ADDR_SZ(12)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_wr(req_wr), .i_req_bank(req_bank), .i_req_addr(req_addr),
    .i_req_t(req_t), .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_err(rsp_err),
    .o_rsp_t(rsp_t), .o_rsp_x(rsp_x), .o_rsp_y(rsp_y), .o_rsp_z(rsp_z),
    .o_mem_cs_ram(cs_ram), .o_mem_cs_rom0(cs_rom0), .o_mem_cs_rom1(cs_rom1),
    .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_field(mem_field),
    .o_mem_data(mem_wdata), .i_mem_data(mem_rdata)
  );

  function automatic int key(input logic [1:0] b, input logic [11:0] a, input logic [1:0] f);
    return int'(b) * 16384 + int'(a) * 4 + int'(f);
  endfunction

  function automatic logic [15:0] sh_get(input int k);
    if (shadow.exists(k)) return shadow[k];
    return 16'h0000;
  endfunction

  // quad_mem model: write at the edge, registered read data.
  always @(posedge clk) begin
    if (cs_ram || cs_rom0 || cs_rom1) begin
      if (mem_wr) mem[key(cs_rom1 ? 2'd2 : (cs_rom0 ? 2'd1 : 2'd0), mem_addr, mem_field)] <= mem_wdata;
      else mem_rdata <= mem[key(cs_rom1 ? 2'd2 : (cs_rom0 ? 2'd1 : 2'd0), mem_addr, mem_field)];
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: compare on each handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) chk("rsp_unexpected", 80'd1, 80'd0);
      else chk("rsp", {15'd0, rsp_err, rsp_t, rsp_x, rsp_y, rsp_z}, sb_q.pop_front());
    end
  end

  // Called just after a rising edge; pushes the expected response.
  task automatic drive_req(input logic wr, input logic [1:0] bank, input logic [11:0] addr,
                           input logic [15:0] t, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] z);
    logic [15:0] w [4];
    w[0] = t; w[1] = x; w[2] = y; w[3] = z;
    if (bank == 2'd3) begin
      sb_q.push_back({15'd0, 1'b1, 64'd0});
    end else if (wr) begin
      for (int f = 0; f < 4; f++) shadow[key(bank, addr, 2'(f))] = w[f];
      sb_q.push_back({16'd0, 64'd0});
    end else begin
      sb_q.push_back({16'd0, sh_get(key(bank, addr, 2'd0)), sh_get(key(bank, addr, 2'd1)),
                      sh_get(key(bank, addr, 2'd2)), sh_get(key(bank, addr, 2'd3))});
    end
    req_valid = 1'b1; req_wr = wr; req_bank = bank; req_addr = addr;
    req_t = t; req_x = x; req_y = y; req_z = z;
  endtask

  // Returns after the accept edge; scrambles inputs to prove they were latched.
  task automatic wait_accept(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (req_ready) break;
      if (waited > 50) begin
        chk("accept_timeout", 80'(waited), 80'd0);
        break;
      end
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_wr = 1'($urandom); req_addr = 12'($urandom);
    req_t = 16'($urandom); req_x = 16'($urandom); req_y = 16'($urandom); req_z = 16'($urandom);
  endtask

  task automatic check_timing(input logic wr, input logic [1:0] bank, input logic [11:0] addr,
                              input logic [15:0] t, input logic [15:0] x,
                              input logic [15:0] y, input logic [15:0] z);
    logic [15:0] w [4];
    logic [2:0]  cs_exp;
    w[0] = t; w[1] = x; w[2] = y; w[3] = z;
    if (bank == 2'd3) begin
      @(negedge clk);
      chk("err_c0_valid", 80'(rsp_valid), 80'd1);
      chk("err_c0_err", 80'(rsp_err), 80'd1);
      chk("err_c0_cs", 80'({cs_rom1, cs_rom0, cs_ram}), 80'd0);
      return;
    end
    cs_exp = 3'b001 << bank;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("c%0d_cs", c), 80'({cs_rom1, cs_rom0, cs_ram}), 80'(cs_exp));
      chk($sformatf("c%0d_wr", c), 80'(mem_wr), 80'(wr));
      chk($sformatf("c%0d_addr", c), 80'(mem_addr), 80'(addr));
      chk($sformatf("c%0d_field", c), 80'(mem_field), 80'(c));
      chk($sformatf("c%0d_data", c), 80'(mem_wdata), wr ? 80'(w[c]) : 80'd0);
      chk($sformatf("c%0d_rsp_valid", c), 80'({rsp_valid, req_ready}), 80'd0);
    end
    @(negedge clk);
    chk("c4_cs", 80'({cs_rom1, cs_rom0, cs_ram, mem_wr}), 80'd0);
    chk("c4_rsp_valid", 80'(rsp_valid), 80'(wr));
    if (!wr) begin
      @(negedge clk);
      chk("c5_rsp_valid", 80'(rsp_valid), 80'd1);
    end
  endtask

  task automatic run_req(input logic wr, input logic [1:0] bank, input logic [11:0] addr,
                         input logic [15:0] t, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] z);
    int waited;
    @(posedge clk); #2;
    drive_req(wr, bank, addr, t, x, y, z);
    wait_accept(waited);
    check_timing(wr, bank, addr, t, x, y, z);
  endtask

  initial begin
    int waited;
    logic [1:0]  rb;
    logic [11:0] ra;
    logic [15:0] r0, r1, r2, r3;
    for (int i = 0; i < 49152; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_bank = 2'd0; req_addr = 12'h005;
    req_t = 16'hDEAD; req_x = 16'hDEAD; req_y = 16'hDEAD; req_z = 16'hDEAD;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("reset_ready", 80'(req_ready), 80'd1);
    chk("reset_outs", {15'd0, rsp_valid, rsp_t, rsp_x, rsp_y, rsp_z}, 80'd0);
    chk("reset_mem", 80'({cs_rom1, cs_rom0, cs_ram, mem_wr, mem_addr, mem_field, mem_wdata}), 80'd0);
    chk("reset_err", 80'(rsp_err), 80'd0);
    @(posedge clk); #2;
    req_valid = 1'b0; rst_n = 1'b1;

    // Write then read back RAM 0x005.
    run_req(1'b1, 2'd0, 12'h005, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_req(1'b0, 2'd0, 12'h005, 16'h0, 16'h0, 16'h0, 16'h0);

    // ROM1 write at the top address, read ROM0 and ROM1 back.
    run_req(1'b1, 2'd2, 12'hFFF, 16'h5A5A, 16'hA5A5, 16'h0F0F, 16'hF0F0);
    run_req(1'b0, 2'd1, 12'hFFF, 16'h0, 16'h0, 16'h0, 16'h0);
    run_req(1'b0, 2'd2, 12'hFFF, 16'h0, 16'h0, 16'h0, 16'h0);

    // Bank 3 error, then a back-to-back request.
    run_req(1'b0, 2'd3, 12'h123, 16'h0, 16'h0, 16'h0, 16'h0);
    run_req(1'b0, 2'd0, 12'h005, 16'h0, 16'h0, 16'h0, 16'h0);

    // Backpressure: hold the read response while a write is offered.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    drive_req(1'b0, 2'd0, 12'h005, 16'h0, 16'h0, 16'h0, 16'h0);
    wait_accept(waited);
    check_timing(1'b0, 2'd0, 12'h005, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (i == 2) drive_req(1'b1, 2'd0, 12'h00A, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
      @(negedge clk);
      chk("bp_hold", {15'd0, rsp_valid, rsp_t, rsp_x, rsp_y, rsp_z},
          {15'd0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444});
      chk("bp_req_ready", 80'({req_ready, cs_ram}), 80'd0);
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    wait_accept(waited);
    chk("bp_accept_delay", 80'(waited), 80'd2);
    check_timing(1'b1, 2'd0, 12'h00A, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);

    // Reset in cycle 1 of a write: only T and X reach memory.
    @(posedge clk); #2;
    req_valid = 1'b1; req_wr = 1'b1; req_bank = 2'd0; req_addr = 12'h005;
    req_t = 16'hAAAA; req_x = 16'hBBBB; req_y = 16'hCCCC; req_z = 16'hDDDD;
    shadow[key(2'd0, 12'h005, 2'd0)] = 16'hAAAA;
    shadow[key(2'd0, 12'h005, 2'd1)] = 16'hBBBB;
    wait_accept(waited);
    @(negedge clk);
    chk("rst_c0", 80'({cs_ram, mem_wr, mem_field, mem_wdata}), 80'({2'b11, 2'd0, 16'hAAAA}));
    @(negedge clk);
    chk("rst_c1", 80'({cs_ram, mem_wr, mem_field, mem_wdata}), 80'({2'b11, 2'd1, 16'hBBBB}));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_c2_strobe", 80'({cs_rom1, cs_rom0, cs_ram, mem_wr}), 80'd0);
    chk("rst_c2_rsp", 80'(rsp_valid), 80'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_idle", 80'({req_ready, rsp_valid, cs_ram}), 80'(3'b100));
    end
    run_req(1'b0, 2'd0, 12'h005, 16'h0, 16'h0, 16'h0, 16'h0);

    // Random write/read pairs across the valid banks.
    for (int i = 0; i < 4; i++) begin
      rb = 2'($urandom_range(0, 2));
      ra = 12'($urandom);
      r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
      run_req(1'b1, rb, ra, r0, r1, r2, r3);
      run_req(1'b0, rb, ra, 16'h0, 16'h0, 16'h0, 16'h0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 80'(sb_q.size()), 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
